// File: rtl/led_pwm_fader_if.sv
// Request/drive bundle between the LED pattern driver and the PWM fader.
// The pattern driver owns enable and led_in; the fader owns led_out and any_active.
interface led_pwm_fader_if;
  logic       enable;
  logic [5:0] led_in;
  logic [5:0] led_out;
  logic       any_active;

  modport master (
    output enable,
    output led_in,
    input  led_out,
    input  any_active
  );

  modport slave (
    input  enable,
    input  led_in,
    output led_out,
    output any_active
  );
endinterface

// File: rtl/led_pwm_fader.sv
// Six-channel LED fader: a lit request snaps a channel to full brightness, and a
// released channel decays linearly, so the PWM drive leaves a fading tail behind it.
module led_pwm_fader #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DECAY_DIV  = 100000,
  parameter int unsigned DECAY_STEP = 8
) (
  input  logic             clk,
  input  logic             rstn,
  led_pwm_fader_if.slave   bus
);

  localparam int                  NUM_CH    = 6;
  localparam int                  PRE_W     = $clog2(DECAY_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

  logic [PRE_W-1:0]                 pre_cnt_q,    pre_cnt_d;
  logic [PWM_BITS-1:0]              pwm_cnt_q,    pwm_cnt_d;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  level_q,      level_d;
  logic [NUM_CH-1:0]                led_out_q,    led_out_d;
  logic                             any_active_q, any_active_d;
  logic                             decay_tick;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pre_cnt_d    = '0;
    pwm_cnt_d    = '0;
    level_d      = level_q;
    led_out_d    = '0;
    any_active_d = 1'b0;
    decay_tick   = (pre_cnt_q == PRE_LAST);

    if (bus.enable) begin
      pre_cnt_d = decay_tick ? '0 : pre_cnt_q + PRE_W'(1);
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      // A fresh request outranks a coincident decay tick.
      if (!bus.enable) begin
        level_d[i] = '0;
      end else if (bus.led_in[i]) begin
        level_d[i] = LEVEL_MAX;
      end else if (decay_tick) begin
        level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : '0;
      end

      // Full level is forced on so MAX gives true 100% duty despite the strict compare.
      led_out_d[i] = bus.enable & ((level_q[i] == LEVEL_MAX) | (level_q[i] > pwm_cnt_q));
      any_active_d = any_active_d | (level_q[i] != '0);
    end

    any_active_d = any_active_d & bus.enable;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      level_q      <= '0;
      led_out_q    <= '0;
      any_active_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      level_q      <= level_d;
      led_out_q    <= led_out_d;
      any_active_q <= any_active_d;
    end
  end

  assign bus.led_out    = led_out_q;
  assign bus.any_active = any_active_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with an integer brightness model compared every cycle,
// plus literal expectations for reset, decay sequence, collision, blanking and sweep.
module tb_led_pwm_fader;

  localparam int DIV  = 4;
  localparam int STEP = 64;
  localparam int FULL = 255;
  localparam int PER  = 256;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_on = 1'b0;

  led_pwm_fader_if bus ();

  led_pwm_fader #(
    .PWM_BITS   (8),
    .DECAY_DIV  (DIV),
    .DECAY_STEP (STEP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: elapsed enabled cycles define both counters; brightness is a plain integer.
  int         m_t;
  int         m_lvl [6];
  logic [5:0] m_out;
  logic       m_any;

  function automatic int next_level(int l, bit en, bit req, bit tick);
    if (!en)  return 0;
    if (req)  return FULL;
    if (tick) return (l - STEP < 0) ? 0 : l - STEP;
    return l;
  endfunction

  function automatic bit any_lit();
    for (int i = 0; i < 6; i++) if (m_lvl[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_t <= 0;
      for (int i = 0; i < 6; i++) m_lvl[i] <= 0;
      m_out <= '0;
      m_any <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        m_lvl[i] <= next_level(m_lvl[i], bus.enable, bus.led_in[i], (m_t % DIV) == DIV - 1);
        m_out[i] <= bus.enable && (m_lvl[i] >= FULL || m_lvl[i] > (m_t % PER));
      end
      m_any <= bus.enable && any_lit();
      m_t   <= bus.enable ? m_t + 1 : 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("led_out_vs_model", 32'(bus.led_out), 32'(m_out));
      check("any_active_vs_model", 32'(bus.any_active), 32'(m_any));
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.enable = 1'b0;
    bus.led_in = '0;
    repeat (2) @(negedge clk);
    check("reset_led_out", 32'(bus.led_out), 32'h0);
    check("reset_any_active", 32'(bus.any_active), 32'h0);
    cmp_on = 1'b1;
    #2 rstn = 1'b1;
    bus.enable = 1'b1;

    // 1: reset mid-fade
    @(negedge clk);
    bus.led_in = 6'b000100;
    @(negedge clk);
    bus.led_in = '0;
    repeat (6) @(negedge clk);
    check("t1_active_before_reset", 32'(bus.any_active), 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("t1_async_led_out", 32'(bus.led_out), 32'h0);
    check("t1_async_any_active", 32'(bus.any_active), 32'h0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t1_idle_led_out", 32'(bus.led_out), 32'h0);
    end
    check("t1_idle_any_active", 32'(bus.any_active), 32'h0);

    // 2: single pulse decay, aligned to a fresh prescaler
    reset_pulse();
    bus.led_in = 6'b000001;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      case (e)
        1: begin
          check("t2_lvl_load", 32'(m_lvl[0]), 32'd255);
          check("t2_latency_led_out", 32'(bus.led_out), 32'h0);
          bus.led_in = '0;
        end
        2: begin
          check("t2_led_out_on", 32'(bus.led_out), 32'h01);
          check("t2_any_on", 32'(bus.any_active), 32'h1);
        end
        4:  check("t2_lvl_191", 32'(m_lvl[0]), 32'd191);
        8:  check("t2_lvl_127", 32'(m_lvl[0]), 32'd127);
        12: check("t2_lvl_63", 32'(m_lvl[0]), 32'd63);
        13: check("t2_led_out_63", 32'(bus.led_out), 32'h01);
        16: begin
          check("t2_lvl_sat_0", 32'(m_lvl[0]), 32'd0);
          check("t2_any_still_on", 32'(bus.any_active), 32'h1);
        end
        17: begin
          check("t2_led_out_off", 32'(bus.led_out), 32'h0);
          check("t2_any_off", 32'(bus.any_active), 32'h0);
        end
        default: ;
      endcase
    end

    // 3: held request spanning the pwm_cnt=255 point
    for (int k = 0; k < 300 && (m_t % PER) != 228; k++) @(negedge clk);
    bus.led_in = 6'b001000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c >= 2) check("t3_held_full", 32'(bus.led_out[3]), 32'h1);
    end
    check("t3_lvl_full", 32'(m_lvl[3]), 32'd255);
    bus.led_in = '0;

    // 4: load coincident with a decay tick while level is 63
    reset_pulse();
    bus.led_in = 6'b100000;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      case (e)
        1:  bus.led_in = '0;
        12: check("t4_lvl_63", 32'(m_lvl[5]), 32'd63);
        15: bus.led_in = 6'b100000;
        16: begin
          check("t4_lvl_reload", 32'(m_lvl[5]), 32'd255);
          bus.led_in = '0;
        end
        17: begin
          check("t4_led_out_kept", 32'(bus.led_out), 32'h20);
          check("t4_any_kept", 32'(bus.any_active), 32'h1);
        end
        default: ;
      endcase
    end

    // 5: enable blanking
    bus.led_in = 6'b111111;
    repeat (2) @(negedge clk);
    check("t5_all_on", 32'(bus.led_out), 32'h3f);
    bus.led_in = '0;
    bus.enable = 1'b0;
    @(negedge clk);
    check("t5_blank_led_out", 32'(bus.led_out), 32'h0);
    check("t5_blank_any", 32'(bus.any_active), 32'h0);
    check("t5_blank_levels", 32'(m_lvl[0] + m_lvl[1] + m_lvl[2] + m_lvl[3] + m_lvl[4] + m_lvl[5]), 32'd0);
    repeat (2) @(negedge clk);
    check("t5_pre_cnt_zero", 32'(dut.pre_cnt_q), 32'h0);
    check("t5_pwm_cnt_zero", 32'(dut.pwm_cnt_q), 32'h0);
    bus.enable = 1'b1;
    @(negedge clk);
    check("t5_pre_cnt_restart", 32'(dut.pre_cnt_q), 32'h1);
    check("t5_pwm_cnt_restart", 32'(dut.pwm_cnt_q), 32'h1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t5_stay_dark", 32'(bus.led_out), 32'h0);
    end

    // 6: walking sweep 0..5..0, four cycles per position
    for (int s = 0; s < 11; s++) begin
      int p;
      p = (s <= 5) ? s : 10 - s;
      bus.led_in = 6'(1 << p);
      repeat (4) @(negedge clk);
      check("t6_current_on", 32'(bus.led_out[p]), 32'h1);
      if (s <= 5) begin
        check("t6_current_lvl", 32'(m_lvl[p]), 32'd255);
        if (p >= 1) check("t6_tail1_lvl", 32'(m_lvl[p-1]), 32'd191);
        if (p >= 2) check("t6_tail2_lvl", 32'(m_lvl[p-2]), 32'd127);
      end
    end
    bus.led_in = '0;
    repeat (24) @(negedge clk);
    check("t6_all_faded", 32'(bus.any_active), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream of the LED pattern driver: takes its six on/off LED requests and produces the PWM-dimmed signals that drive the board LEDs. Each lit request snaps its channel to full brightness. When the request drops, brightness decays linearly, so a sweeping pattern leaves a fading tail. Single clock domain; inputs are already synchronous to `clk`.

## Interface
- `PWM_BITS`, default 8: width of PWM counter and per-channel brightness level; MAX = 2^PWM_BITS-1.
- `DECAY_DIV`, default 100000: clocks per decay tick; legal range ≥ 2.
- `DECAY_STEP`, default 8: brightness subtracted per decay tick; legal range 1..MAX.
- `clk` input 1: single system clock.
- `rstn` input 1: asynchronous, active-low reset.
- `enable` input 1: block enable; low blanks and clears all channels.
- `led_in` input 6: brightness requests from pattern driver, bit i = LED i, level-sensitive.
- `led_out` output 6: PWM LED drive, registered.
- `any_active` output 1: registered; high when any channel level ≠ 0.

## Operation
- Prescaler `pre_cnt`, width ceil(log2(DECAY_DIV)):
  - Counts 0..DECAY_DIV-1, then wraps to 0.
  - `decay_tick` is a one-cycle strobe, high while pre_cnt == DECAY_DIV-1.
- PWM counter `pwm_cnt`, PWM_BITS wide: free-running, wraps MAX→0.
- Per-channel level[i], PWM_BITS wide, updated each clock in this priority:
  1. enable low → 0.
  2. led_in[i] high → MAX. This load beats a coincident decay_tick.
  3. decay_tick high → level − DECAY_STEP if level > DECAY_STEP, else 0. Saturating; never wraps below 0.
  4. Otherwise hold.
- Output compare per channel, registered: led_out[i] = enable & ((level[i] == MAX) | (level[i] > pwm_cnt)).
  - Level MAX gives 100% duty.
  - Level 0 gives 0% duty.
  - Level L (0 < L < MAX) gives L/2^PWM_BITS duty.
- `any_active` is registered: OR over i of (level[i] ≠ 0).
- enable low:
  - pre_cnt, pwm_cnt and all levels load 0.
  - led_out and any_active go 0 on the next edge.
- enable high again: counters restart from 0, and channels relight only via led_in.
- Channels are fully independent; any led_in combination is legal, including all six high.
- No state machine beyond the counters. The prescaler, the PWM counter and the six level registers form the complete state.

## Timing
- Reset (rstn low, asynchronous, any time including mid-fade):
  - pre_cnt, pwm_cnt and level[*] are 0.
  - led_out = 6'b000000 and any_active = 0 immediately.
  - First update occurs on the first rising edge after rstn deasserts.
- Latency, led_in to led_out:
  - led_in[i] sampled high at edge N → level[i] = MAX after edge N.
  - led_out[i] = 1 after edge N+1 (2-edge latency).
  - any_active has the same latency.
- A one-cycle led_in pulse is sufficient to load MAX.
- Decay: the first decay_tick occurs DECAY_DIV cycles after reset or enable.
  - From MAX, channel reaches 0 after ceil(MAX/DECAY_STEP) ticks at most.
  - led_out then goes to 0 one edge after level reaches 0.
- pre_cnt and pwm_cnt both count in every cycle while enable is high, regardless of led_in.
- enable deassert at edge N: led_out = 0 after edge N, with no partial PWM period.

## Test plan
Bench parameters: PWM_BITS=8, DECAY_DIV=4, DECAY_STEP=64.
1. Reset mid-fade:
   - Stimulus: pulse led_in[2], wait 6 cycles, drop rstn asynchronously between edges.
   - Response: led_out=0 and any_active=0 with no clock; after release, outputs stay 0 while led_in=0.
2. Single pulse decay:
   - Stimulus: led_in=6'b000001 for 1 cycle.
   - Response: led_out[0]=1 two edges later. Level sequence on successive ticks is 255→191→127→63→0, where 63 saturates to 0. Measured duty over a 256-cycle window equals level/256 at each step. any_active falls one edge after level 0.
3. Held request:
   - Stimulus: led_in[3]=1 for 40 cycles, spanning 10 decay ticks.
   - Response: level stays 255 and led_out[3]=1 every cycle, including pwm_cnt=255.
4. Tick/load collision:
   - Stimulus: raise led_in[5] on the exact cycle decay_tick=1 while level[5]=63.
   - Response: level[5]=255, not 0.
5. Enable blanking:
   - Stimulus: all six channels at 255; drop enable for 3 cycles; reassert with led_in=0.
   - Response: led_out=0 one edge after the drop, and levels 0. After reassert, pre_cnt and pwm_cnt restart at 0 and outputs stay 0.
6. Walking sweep:
   - Stimulus: one-hot led_in walking 0→5→0, 4 cycles per position.
   - Response: the current LED is at level 255; each trailing LED's level is 255 − 64 × (decay ticks since its request dropped), saturating at 0. No two channels interfere.
